dec_tree_pipe: RTL
==================

Name: dec_tree_pipe

Overview:
- Parametrised, pipelined binary-to-one-hot decoder: IN_W-bit code to 2**IN_W one-hot lines.
- Built as a two-level tree. Stage 1 decodes the high bits into registered group enables. Stage 2 decodes the low bits inside the enabled group.
- Adds a valid/ready handshake with backpressure, a global enable, and an auto-scan mode that walks every output line in turn.
- Used as the channel/row select generator wherever the fixed 4x16 combinational decoders no longer meet width or timing.

Parameters:
- IN_W, 4, code width; legal range 2..8.
- HI_W, IN_W/2, bits decoded in stage 1; LO_W = IN_W-HI_W is derived as a localparam.
- OUT_W is derived as a localparam, equal to 2**IN_W. It is not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  decoder enable; sampled with each accepted beat
- mode  in  1  0 = direct (use in_code), 1 = scan (internal counter)
- in_valid  in  1  input beat valid (direct mode only)
- in_ready  out  1  stage 1 can accept a beat
- in_code  in  IN_W  code to decode
- out_valid  out  1  y/y_code valid
- out_ready  in  1  downstream accepts the beat
- y  out  OUT_W  one-hot decoded output
- y_code  out  IN_W  code that produced y
- scan_wrap  out  1  high on the output beat carrying code OUT_W-1 in scan mode

Behaviour:
- Reset (async assert, sync deassert handled by the top level) forces:
  - all stage valids, out_valid = 0
  - y = 0, y_code = 0, scan_wrap = 0
  - scan counter = 0
  - in_ready rises the first cycle after reset is released.
- Pipeline and handshake:
  - Two register stages; latency is 2 cycles from acceptance to out_valid.
  - Stage 2 advances when out_ready=1 or out_valid=0.
  - Stage 1 advances when stage 2 advances or stage 1 is empty.
  - in_ready equals the stage 1 advance condition. It is combinational from out_ready.
  - Full throughput: 1 beat per cycle while out_ready=1.
  - When out_ready=0 with both stages full, all registers hold and in_ready=0.
  - out_valid, y, y_code and scan_wrap are stable while out_valid=1 and out_ready=0.
- Stage 1 captures on acceptance:
  - group enable: one-hot of code[IN_W-1:LO_W] (2**HI_W bits), ANDed with en
  - the low bits code[LO_W-1:0]
  - the full code and the wrap flag
- Stage 2:
  - group g of y (bits g*2**LO_W .. (g+1)*2**LO_W-1) is the one-hot of the low bits, gated by group enable bit g.
  - Every other bit of y is 0.
- en=0 on an accepted beat: the beat still flows through with y = 0 and y_code = the code.
- Direct mode: a beat is accepted when in_valid && in_ready.
- Scan mode:
  - in_valid and in_code are ignored.
  - The internal source is always valid, so a beat is accepted whenever in_ready=1.
  - The code is the counter value; the counter increments on each acceptance.
  - The counter wraps from OUT_W-1 to 0. The wrapping beat carries scan_wrap=1; all other beats carry 0.
- Mode switching:
  - mode is sampled per accepted beat. Beats already in the pipe complete unchanged.
  - A 0->1 transition of mode, seen by a registered mode_d, clears the counter to 0, so scan always starts at code 0.
  - A 1->0 transition leaves the counter value irrelevant.
- Reset mid-operation drops in-flight beats immediately. No partial output is ever presented.
- Invariant: y has at most one bit set in every cycle.

Optional Feature:
- Macro: DEC_TREE_ACTIVE_LOW_EN.
- Defined: y is driven as the bitwise inverse of the one-hot value (74x138 style).
  - The selected line is 0 and all others are 1.
  - y resets to all ones; en=0 beats produce all ones.
  - Handshake, y_code and scan_wrap are unchanged.
- Undefined: active-high one-hot as described above.

Decomposition:
- Package dec_tree_pkg holds:
  - a function onehot(code, width) returning a bit-vector decode
  - MODE_DIRECT = 1'b0 and MODE_SCAN = 1'b1 constants
  - the IN_W legal-range check used by an elaboration assertion
- One natural sub-module: dec_tree_stage, a registered N-to-2**N decoder slice with an enable and a hold input.
  - Instantiated once for stage 1 (HI_W).
  - Instantiated 2**HI_W times for stage 2 (LO_W, each gated by its group bit).

Test Plan:
- Direct sweep (IN_W=4, en=1, out_ready=1): in_code 0..15 on consecutive cycles -> 2 cycles later, y = 1<<code each cycle, y_code matches, out_valid stays high for 16 cycles.
- Enable gating: in_code=9, en=0 -> y = 16'h0000 with y_code = 9. Then in_code=9, en=1 -> y = 16'h0200.
- Backpressure: stream codes 3,4,5 and hold out_ready=0 after the first output -> y = 16'h0008 held, in_ready=0 once both stages are full. Release -> 16'h0010 then 16'h0020, no loss or duplication.
- Scan mode: mode=1, out_ready=1 for 20 cycles -> codes 0..15 then 0..3. scan_wrap=1 only on the code-15 beat. in_valid toggling has no effect.
- Reset mid-stream: assert rst_n=0 while out_valid=1 with y = 16'h0400 -> y = 0 and out_valid = 0 asynchronously. After release, mode=1 restarts from code 0.
- Parameter/macro variants: IN_W=6 sweep of all 64 codes is one-hot correct. With DEC_TREE_ACTIVE_LOW_EN, code 2 gives y = 16'hFFFB and reset gives 16'hFFFF.

Source files
------------

// File: rtl/dec_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_tree_pkg
// Purpose  : Shared constants and helpers for the dec_tree_pipe decoder.
//            - MODE_DIRECT / MODE_SCAN source-select encodings
//            - in_w_legal() range check used by the top-level elaboration check
//            - onehot() generic binary-to-one-hot decode (up to 256 lines)
// Macro    : DEC_TREE_ACTIVE_LOW_EN (consumed by dec_tree_pipe, not here)
// Revision : 1.0 - initial release
// ============================================================================
package dec_tree_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int c_in_w_min   = 2;
  localparam int c_in_w_max   = 8;
  localparam int c_onehot_max = 256;

  function automatic bit in_w_legal(input int w);
    return (w >= c_in_w_min) && (w <= c_in_w_max);
  endfunction

  // Codes at or beyond 'width' decode to all zeros so a caller can never
  // see a stray bit outside its own slice.
  function automatic logic [c_onehot_max-1:0] onehot(input logic [7:0] code,
                                                     input int unsigned width);
    logic [c_onehot_max-1:0] v;
    v = '0;
    if (code < width) v[code] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec_tree_if.sv
`default_nettype none
// ============================================================================
// Module   : dec_tree_if
// Purpose  : Handshake / data bundle between a code source and dec_tree_pipe.
// Ports    : en, mode, in_valid, in_code, out_ready  (source -> decoder)
//            in_ready, out_valid, y, y_code, scan_wrap (decoder -> source)
//            master = driving side, slave = decoder side
// Revision : 1.0 - initial release
// ============================================================================
interface dec_tree_if #(
  parameter int IN_W = 4
);
  localparam int OUT_W = 2 ** IN_W;

  logic             en;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_code;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] y;
  logic [IN_W-1:0]  y_code;
  logic             scan_wrap;

  modport master (
    output en, mode, in_valid, in_code, out_ready,
    input  in_ready, out_valid, y, y_code, scan_wrap
  );

  modport slave (
    input  en, mode, in_valid, in_code, out_ready,
    output in_ready, out_valid, y, y_code, scan_wrap
  );

endinterface
`default_nettype wire

// File: rtl/dec_tree_stage.sv
`default_nettype none
// ============================================================================
// Module   : dec_tree_stage
// Purpose  : Registered N-to-2**N one-hot decoder slice.
// Ports    : clk, rst_n  - clock, async active-low reset (q clears to 0)
//            hold        - 1 keeps q unchanged
//            enable      - 0 loads all zeros instead of the decode
//            code [N]    - binary input
//            q [2**N]    - registered one-hot output
// Revision : 1.0 - initial release
// ============================================================================
module dec_tree_stage
  import dec_tree_pkg::*;
#(
  parameter int N = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              hold,
  input  wire logic              enable,
  input  wire logic [N-1:0]      code,
  output logic      [(1<<N)-1:0] q
);

  localparam int unsigned c_w = 1 << N;

  logic [c_w-1:0] w_dec;
  logic [c_w-1:0] r_q;

  assign w_dec = c_w'(onehot(8'(code), c_w));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (!hold) begin
      r_q <= enable ? w_dec : '0;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/dec_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dec_tree_pipe
// Purpose  : Two-stage pipelined IN_W-to-2**IN_W one-hot decoder with a
//            valid/ready handshake, global enable and auto-scan source.
//            Stage 1 registers group enables (high bits), stage 2 decodes the
//            low bits inside the enabled group.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - dec_tree_if.slave (en, mode, in_valid/in_ready, in_code,
//                     out_valid/out_ready, y, y_code, scan_wrap)
// Macro    : DEC_TREE_ACTIVE_LOW_EN - when defined y is the bitwise inverse of
//            the one-hot value (selected line low, resets to all ones).
// Revision : 1.0 - initial release
// ============================================================================
module dec_tree_pipe
  import dec_tree_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int HI_W = IN_W / 2
) (
  input wire logic  clk,
  input wire logic  rst_n,
  dec_tree_if.slave bus
);

  localparam int LO_W    = IN_W - HI_W;
  localparam int OUT_W   = 2 ** IN_W;
  localparam int c_grp_n = 2 ** HI_W;
  localparam int c_grp_w = 2 ** LO_W;
  localparam logic [IN_W-1:0] c_code_max = '1;

  if (!in_w_legal(IN_W) || (HI_W < 1) || (HI_W >= IN_W)) begin : g_bad_param
    $error("dec_tree_pipe: IN_W must be 2..8 and HI_W 1..IN_W-1");
  end

  // ---------------------------------------------------------------- control
  logic            r_rdy;       // low during reset and the first cycle after
  logic            r_mode_d;
  logic [IN_W-1:0] r_cnt;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_scan;
  logic            w_scan_start;
  logic [IN_W-1:0] w_cnt_eff;
  logic            w_src_valid;
  logic [IN_W-1:0] w_src_code;
  logic            w_src_wrap;
  logic            w_accept;

  logic            r_s1_valid;
  logic [LO_W-1:0] r_s1_lo;
  logic [IN_W-1:0] r_s1_code;
  logic            r_s1_wrap;
  logic [c_grp_n-1:0] w_grp;

  logic            r_s2_valid;
  logic [IN_W-1:0] r_s2_code;
  logic            r_s2_wrap;
  logic [OUT_W-1:0] w_y_hot;

  assign w_adv2 = bus.out_ready || !r_s2_valid;
  assign w_adv1 = r_rdy && (w_adv2 || !r_s1_valid);

  // A fresh entry into scan mode starts the walk at code 0 in the same cycle,
  // so the first scan beat never carries a stale counter value.
  assign w_scan       = (bus.mode == MODE_SCAN);
  assign w_scan_start = w_scan && !r_mode_d;
  assign w_cnt_eff    = w_scan_start ? '0 : r_cnt;

  assign w_src_valid = w_scan ? 1'b1 : bus.in_valid;
  assign w_src_code  = w_scan ? w_cnt_eff : bus.in_code;
  assign w_src_wrap  = w_scan && (w_cnt_eff == c_code_max);
  assign w_accept    = w_adv1 && w_src_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy      <= 1'b0;
      r_mode_d   <= MODE_DIRECT;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_s1_lo    <= '0;
      r_s1_code  <= '0;
      r_s1_wrap  <= 1'b0;
    end else begin
      r_rdy    <= 1'b1;
      r_mode_d <= bus.mode;
      if (w_scan && w_accept) begin
        r_cnt <= w_cnt_eff + 1'b1;
      end else if (w_scan_start) begin
        r_cnt <= '0;
      end
      if (w_adv1) begin
        r_s1_valid <= w_accept;
        if (w_accept) begin
          r_s1_lo   <= w_src_code[LO_W-1:0];
          r_s1_code <= w_src_code;
          r_s1_wrap <= w_src_wrap;
        end
      end
    end
  end

  // --------------------------------------------------------------- stage 1
  dec_tree_stage #(.N(HI_W)) u_stage1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (!w_accept),
    .enable (bus.en),
    .code   (w_src_code[IN_W-1:LO_W]),
    .q      (w_grp)
  );

  // --------------------------------------------------------------- stage 2
  // Group enables are qualified by stage-1 valid so a bubble moving into
  // stage 2 produces y = 0 rather than replaying the previous group.
  for (genvar g = 0; g < c_grp_n; g++) begin : g_stage2
    dec_tree_stage #(.N(LO_W)) u_lo (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold   (!w_adv2),
      .enable (w_grp[g] && r_s1_valid),
      .code   (r_s1_lo),
      .q      (w_y_hot[g*c_grp_w +: c_grp_w])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_code  <= '0;
      r_s2_wrap  <= 1'b0;
    end else if (w_adv2) begin
      r_s2_valid <= r_s1_valid;
      r_s2_code  <= r_s1_code;
      r_s2_wrap  <= r_s1_wrap && r_s1_valid;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.in_ready  = w_adv1;
  assign bus.out_valid = r_s2_valid;
  assign bus.y_code    = r_s2_code;
  assign bus.scan_wrap = r_s2_wrap;

`ifdef DEC_TREE_ACTIVE_LOW_EN
  assign bus.y = ~w_y_hot;
`else
  assign bus.y = w_y_hot;
`endif

endmodule
`default_nettype wire
